// File: rtl/imm_ext_pipe.sv
// Immediate extender: computes the extended value at input time and queues it
// in a 2-entry in-order buffer with valid/ready handshakes on both sides.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_con,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] data;
  } entry_t;

  if (OUT_W < 2 * IN_W) begin : g_bad_params
    $error("imm_ext_pipe: OUT_W must be at least 2*IN_W");
  end

  entry_t     mem_q [2];
  logic [1:0] cnt_q, cnt_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  entry_t     ext;
  logic [OUT_W-1:0] zext, sext;
  logic       push, pop;

  always_comb begin
    ext  = '0;
    zext = OUT_W'(in_imm);
    sext = OUT_W'($signed(in_imm));
    case (in_con)
      3'd0:    ext.data = sext;
      3'd1:    ext.data = zext;
      // Sign-extending to full width then shifting equals extending to OUT_W-2 first.
      3'd2:    ext.data = sext << 2;
      3'd3:    ext.data = zext << IN_W;
      default: ext.err  = 1'b1;
    endcase
  end

  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? mem_q[rd_ptr_q].data : '0;
  assign out_err   = out_valid ? mem_q[rd_ptr_q].err  : 1'b0;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      cnt_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= ext;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: table of single-entry extensions plus
// hand-written backpressure, flush and reset sequences.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_imm;
  logic [2:0]  in_con;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_con(in_con),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  con;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [15:0] imm, input logic [2:0] con);
    in_valid = v;
    in_imm   = imm;
    in_con   = con;
  endtask

  initial begin
    vecs[0] = '{16'h8004, 3'd0, 32'hFFFF8004, 1'b0};
    vecs[1] = '{16'h8004, 3'd1, 32'h00008004, 1'b0};
    vecs[2] = '{16'h8004, 3'd2, 32'hFFFE0010, 1'b0};
    vecs[3] = '{16'h8004, 3'd3, 32'h80040000, 1'b0};
    vecs[4] = '{16'h1234, 3'd5, 32'h00000000, 1'b1};
    vecs[5] = '{16'h7FFF, 3'd0, 32'h00007FFF, 1'b0};
    vecs[6] = '{16'h7FFF, 3'd2, 32'h0001FFFC, 1'b0};
    vecs[7] = '{16'hFFFF, 3'd1, 32'h0000FFFF, 1'b0};
    vecs[8] = '{16'hFFFF, 3'd3, 32'hFFFF0000, 1'b0};
    vecs[9] = '{16'hABCD, 3'd7, 32'h00000000, 1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 16'h0, 3'd0);
    tick(); tick();
    rst = 1'b0;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_err", {31'b0, out_err}, 32'd0);

    // Popping an empty buffer must not underflow.
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("empty pop out_valid", {31'b0, out_valid}, 32'd0);
    chk("empty pop in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, vecs[i].imm, vecs[i].con);
      tick();
      drive_in(1'b0, 16'h0, 3'd0);
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d out_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), {31'b0, out_valid}, 32'd0);
    end

    // Back-to-back pushes under backpressure.
    drive_in(1'b1, 16'h0001, 3'd1);
    tick();
    drive_in(1'b1, 16'h0002, 3'd1);
    chk("b2b in_ready after 1", {31'b0, in_ready}, 32'd1);
    chk("b2b head A", out_data, 32'h00000001);
    tick();
    drive_in(1'b1, 16'h0003, 3'd1);
    chk("b2b in_ready full", {31'b0, in_ready}, 32'd0);
    chk("b2b head A held", out_data, 32'h00000001);
    tick();
    chk("b2b C rejected in_ready", {31'b0, in_ready}, 32'd0);
    chk("b2b head A stable", out_data, 32'h00000001);
    out_ready = 1'b1;
    tick();
    chk("b2b head B", out_data, 32'h00000002);
    chk("b2b in_ready after pop", {31'b0, in_ready}, 32'd1);
    tick();
    drive_in(1'b0, 16'h0, 3'd0);
    chk("b2b head C", out_data, 32'h00000003);
    chk("b2b valid C", {31'b0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b0;
    chk("b2b drained", {31'b0, out_valid}, 32'd0);

    // Flush with full buffer and a same-cycle input.
    drive_in(1'b1, 16'h0011, 3'd1);
    tick();
    drive_in(1'b1, 16'h0022, 3'd1);
    tick();
    chk("flush pre full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive_in(1'b1, 16'h0033, 3'd1);
    tick();
    flush = 1'b0;
    drive_in(1'b0, 16'h0, 3'd0);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    drive_in(1'b1, 16'h0055, 3'd1);
    tick();
    drive_in(1'b0, 16'h0, 3'd0);
    chk("post flush head", out_data, 32'h00000055);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post flush drained", {31'b0, out_valid}, 32'd0);

    // Reset mid-operation with one held entry.
    drive_in(1'b1, 16'h0066, 3'd1);
    tick();
    drive_in(1'b0, 16'h0, 3'd0);
    chk("pre rst valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst out_data", out_data, 32'd0);
    chk("mid rst out_err", {31'b0, out_err}, 32'd0);
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    drive_in(1'b1, 16'h0077, 3'd1);
    tick();
    drive_in(1'b0, 16'h0, 3'd0);
    chk("post rst head", out_data, 32'h00000077);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post rst drained", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
